// File: rtl/rx_buf_pkg.sv
`default_nettype none
// ==== rx_buf_pkg : shared types and defaults for the receive-buffer writer | rev 1.0 ====
package rx_buf_pkg;

  localparam int c_def_addr_w = 6;
  localparam int c_def_data_w = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECV     = 2'd1,
    COMMIT   = 2'd2,
    ROLLBACK = 2'd3
  } state_t;

  typedef logic [c_def_addr_w:0] ptr_t;

endpackage
`default_nettype wire

// File: rtl/rx_buf_wr_ctrl_if.sv
`default_nettype none
// ==== rx_buf_wr_ctrl_if : byte-stream input and buffer-write output bundle | rev 1.0 ====
interface rx_buf_wr_ctrl_if
  import rx_buf_pkg::*;
#(
  parameter int ADDR_W = c_def_addr_w,
  parameter int DATA_W = c_def_data_w
);

  logic              pkt_start;
  logic              byte_valid;
  logic [DATA_W-1:0] byte_data;
  logic              pkt_end;
  logic              pkt_error;
  logic [ADDR_W:0]   rd_ptr;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   commit_ptr;
  logic [ADDR_W:0]   pkt_len;
  logic              pkt_done;
  logic              pkt_drop;
  logic              overflow;
  logic              ready;

  modport master (
    output pkt_start, byte_valid, byte_data, pkt_end, pkt_error, rd_ptr,
    input  wr_en, wr_addr, wr_data, commit_ptr, pkt_len, pkt_done, pkt_drop, overflow, ready
  );

  modport slave (
    input  pkt_start, byte_valid, byte_data, pkt_end, pkt_error, rd_ptr,
    output wr_en, wr_addr, wr_data, commit_ptr, pkt_len, pkt_done, pkt_drop, overflow, ready
  );

endinterface
`default_nettype wire

// File: rtl/rx_ptr_counter.sv
`default_nettype none
// ==== rx_ptr_counter : wrap-bit address counter with load-over-increment | rev 1.0 ====
module rx_ptr_counter #(
  parameter int ADDR_W = 6
) (
  input  wire logic              clk,
  input  wire logic              n_rst,
  input  wire logic              inc,
  input  wire logic              load,
  input  wire logic [ADDR_W:0]   load_val,
  output logic      [ADDR_W:0]   ptr
);

  localparam logic [ADDR_W:0] c_one = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] r_ptr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ptr <= '0;
    end else if (load) begin
      r_ptr <= load_val;
    end else if (inc) begin
      r_ptr <= r_ptr + c_one;
    end
  end

  assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/rx_buf_wr_ctrl.sv
`default_nettype none
// ==== rx_buf_wr_ctrl : speculative circular-buffer writer, commits whole good packets | rev 1.0 ====
module rx_buf_wr_ctrl
  import rx_buf_pkg::*;
#(
  parameter int ADDR_W = c_def_addr_w,
  parameter int DATA_W = c_def_data_w
) (
  input wire logic        clk,
  input wire logic        n_rst,
  rx_buf_wr_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] c_depth = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [ADDR_W:0]   r_commit_ptr;
  logic [ADDR_W:0]   r_pkt_len;
  logic              r_pkt_done;
  logic              r_pkt_drop;
  logic              r_overflow;
  logic              r_ready;

  logic [ADDR_W:0]   w_wr_cur;
  logic [ADDR_W:0]   w_ptr_diff;
  logic [ADDR_W:0]   w_len_next;
  logic              w_full;
  logic              w_accept;
  logic              w_load;

  // Occupancy includes the uncommitted bytes of the packet in flight.
  assign w_ptr_diff = w_wr_cur - bus.rd_ptr;
  assign w_full     = (w_ptr_diff == c_depth);
  assign w_accept   = (r_state == RECV) && bus.byte_valid && !bus.pkt_error
                      && !bus.pkt_start && !w_full;
  assign w_load     = (r_state == ROLLBACK);
  assign w_len_next = r_len + {{ADDR_W{1'b0}}, w_accept};

  rx_ptr_counter #(
    .ADDR_W (ADDR_W)
  ) u_wr_cur (
    .clk      (clk),
    .n_rst    (n_rst),
    .inc      (w_accept),
    .load     (w_load),
    .load_val (r_commit_ptr),
    .ptr      (w_wr_cur)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_commit_ptr <= '0;
      r_pkt_len    <= '0;
      r_pkt_done   <= 1'b0;
      r_pkt_drop   <= 1'b0;
      r_overflow   <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_wr_en    <= w_accept;
      r_pkt_done <= 1'b0;
      r_pkt_drop <= 1'b0;
      r_overflow <= 1'b0;
      if (w_accept) begin
        r_wr_addr <= w_wr_cur[ADDR_W-1:0];
        r_wr_data <= bus.byte_data;
        r_len     <= w_len_next;
      end
      case (r_state)
        IDLE: begin
          if (bus.pkt_start) begin
            r_state <= RECV;
            r_len   <= '0;
            r_ready <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        RECV: begin
          r_ready <= 1'b0;
          if (bus.pkt_error || bus.pkt_start) begin
            r_state <= ROLLBACK;
          end else if (bus.byte_valid && w_full) begin
            r_overflow <= 1'b1;
            r_state    <= ROLLBACK;
          end else if (bus.pkt_end) begin
            r_state <= (w_len_next != '0) ? COMMIT : ROLLBACK;
          end
        end
        COMMIT: begin
          r_commit_ptr <= w_wr_cur;
          r_pkt_len    <= r_len;
          r_pkt_done   <= 1'b1;
          r_ready      <= 1'b1;
          r_state      <= IDLE;
        end
        ROLLBACK: begin
          r_pkt_drop <= 1'b1;
          r_ready    <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.commit_ptr = r_commit_ptr;
  assign bus.pkt_len    = r_pkt_len;
  assign bus.pkt_done   = r_pkt_done;
  assign bus.pkt_drop   = r_pkt_drop;
  assign bus.overflow   = r_overflow;
  assign bus.ready      = r_ready;

endmodule
`default_nettype wire
